// File: rtl/sdram_bus_arbiter.sv
// Hands the shared SDRAM pin bus between the camera (0) and HPS (1) controllers with a drain + NOP guard gap.
// Pins are registered once and always follow the registered owner; masters must release and report idle to hand over.
module sdram_bus_arbiter #(
  parameter int GUARD_CYCLES = 4,
  parameter int MAX_HOLD     = 4096
) (
  input  logic        CLOCK_50_i,
  input  logic        RESET_N_i,
  input  logic        pref_cam_i,
  input  logic [1:0]  m_req_i,
  input  logic [1:0]  m_idle_i,
  output logic [1:0]  m_gnt_o,
  output logic [1:0]  m_yield_o,
  input  logic [3:0]  m0_cmd_i,
  input  logic [12:0] m0_addr_i,
  input  logic [1:0]  m0_ba_i,
  input  logic [1:0]  m0_dqm_i,
  input  logic        m0_cke_i,
  input  logic [3:0]  m1_cmd_i,
  input  logic [12:0] m1_addr_i,
  input  logic [1:0]  m1_ba_i,
  input  logic [1:0]  m1_dqm_i,
  input  logic        m1_cke_i,
  output logic [3:0]  dram_cmd_o,
  output logic [12:0] dram_addr_o,
  output logic [1:0]  dram_ba_o,
  output logic [1:0]  dram_dqm_o,
  output logic        dram_cke_o,
  output logic [1:0]  owner_o
);

  typedef struct packed {
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic [1:0]  ba;
    logic [1:0]  dqm;
    logic        cke;
  } pins_t;

  typedef enum logic [1:0] {IDLE, OWN, DRAIN, GUARD} state_t;

  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES - 1);
  localparam pins_t PINS_NOP = '{cmd: 4'b1111, addr: 13'd0, ba: 2'd0, dqm: 2'b11, cke: 1'b1};

  state_t        state_q, state_d;
  logic          cur_q, cur_d;
  logic [7:0]    guard_q, guard_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    pref_q;
  logic          pref_sync;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    yield_q, yield_d;
  logic [1:0]    owner_q, owner_d;
  pins_t         pins_q, pins_d;
  pins_t         m0_pins, m1_pins;

  assign pref_sync = pref_q[1];
  assign m0_pins   = '{cmd: m0_cmd_i, addr: m0_addr_i, ba: m0_ba_i, dqm: m0_dqm_i, cke: m0_cke_i};
  assign m1_pins   = '{cmd: m1_cmd_i, addr: m1_addr_i, ba: m1_ba_i, dqm: m1_dqm_i, cke: m1_cke_i};

  always_ff @(posedge CLOCK_50_i or negedge RESET_N_i) begin
    if (!RESET_N_i) begin
      state_q <= IDLE;
      cur_q   <= 1'b0;
      guard_q <= '0;
      hold_q  <= '0;
      pref_q  <= '0;
      gnt_q   <= '0;
      yield_q <= '0;
      owner_q <= '0;
      pins_q  <= PINS_NOP;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      guard_q <= guard_d;
      hold_q  <= hold_d;
      pref_q  <= {pref_q[0], pref_cam_i};
      gnt_q   <= gnt_d;
      yield_q <= yield_d;
      owner_q <= owner_d;
      pins_q  <= pins_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    guard_d = guard_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (|m_req_i) begin
          state_d = OWN;
          cur_d   = (&m_req_i) ? ~pref_sync : m_req_i[1];
          hold_d  = '0;
        end
      end
      OWN: begin
        if (!m_req_i[cur_q]) begin
          state_d = DRAIN;
        end else if (m_req_i[~cur_q]) begin
          if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
        end else if (hold_q != HOLD_MAX) begin
          // waiter gave up before saturating: its patience starts over
          hold_d = '0;
        end
      end
      DRAIN: begin
        if (m_idle_i[cur_q]) begin
          state_d = GUARD;
          guard_d = GUARD_LOAD;
        end
      end
      GUARD: begin
        if (guard_q == 8'd0) state_d = IDLE;
        else                 guard_d = guard_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from next state so grant, owner and pins all update on the same edge
  always_comb begin
    gnt_d   = '0;
    yield_d = '0;
    owner_d = '0;
    pins_d  = PINS_NOP;
    if (state_d == OWN) gnt_d[cur_d] = 1'b1;
    if (state_d == OWN || state_d == DRAIN) begin
      owner_d[cur_d] = 1'b1;
      pins_d         = cur_d ? m1_pins : m0_pins;
    end
    if (MAX_HOLD > 0 && state_d == OWN && hold_d == HOLD_MAX) yield_d[cur_d] = 1'b1;
  end

  assign m_gnt_o     = gnt_q;
  assign m_yield_o   = yield_q;
  assign owner_o     = owner_q;
  assign dram_cmd_o  = pins_q.cmd;
  assign dram_addr_o = pins_q.addr;
  assign dram_ba_o   = pins_q.ba;
  assign dram_dqm_o  = pins_q.dqm;
  assign dram_cke_o  = pins_q.cke;

endmodule

// File: tb/tb_sdram_bus_arbiter.sv
// Self-checking bench for sdram_bus_arbiter: directed handover/tie/hog/reset scenarios plus a random soak,
// all compared every cycle against a bus-ownership reference model.
module tb_sdram_bus_arbiter;
  localparam int GC = 4;
  localparam int MH = 16;
  localparam logic [21:0] NOP = {4'b1111, 13'd0, 2'd0, 2'b11, 1'b1};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pref;
  logic [1:0]  req, idle;
  logic [3:0]  c0, c1;
  logic [12:0] a0, a1;
  logic [1:0]  b0, b1, d0, d1;
  logic        k0, k1;
  logic [1:0]  gnt, yld, own;
  logic [3:0]  dcmd;
  logic [12:0] daddr;
  logic [1:0]  dba, ddqm;
  logic        dcke;

  sdram_bus_arbiter #(.GUARD_CYCLES(GC), .MAX_HOLD(MH)) dut (
    .CLOCK_50_i(clk), .RESET_N_i(rst_n), .pref_cam_i(pref),
    .m_req_i(req), .m_idle_i(idle), .m_gnt_o(gnt), .m_yield_o(yld),
    .m0_cmd_i(c0), .m0_addr_i(a0), .m0_ba_i(b0), .m0_dqm_i(d0), .m0_cke_i(k0),
    .m1_cmd_i(c1), .m1_addr_i(a1), .m1_ba_i(b1), .m1_dqm_i(d1), .m1_cke_i(k1),
    .dram_cmd_o(dcmd), .dram_addr_o(daddr), .dram_ba_o(dba), .dram_dqm_o(ddqm),
    .dram_cke_o(dcke), .owner_o(own)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who holds the pins, whether they still hold the grant,
  // how many guard NOP cycles remain, and how long the other side has waited.
  int          holder;
  bit          granted;
  int          nop_left;
  int          waited;
  bit          p_mid, p_sync;
  logic [21:0] e_pins;

  task automatic model_reset();
    holder = -1; granted = 0; nop_left = 0; waited = 0;
    p_mid = 0; p_sync = 0; e_pins = NOP;
  endtask

  function automatic logic [21:0] mpins(input int m);
    return (m == 1) ? {c1, a1, b1, d1, k1} : {c0, a0, b0, d0, k0};
  endfunction

  task automatic model_edge();
    if (holder < 0 && nop_left == 0) begin
      if (req != 2'b00) begin
        holder  = (req == 2'b11) ? (p_sync ? 0 : 1) : (req[1] ? 1 : 0);
        granted = 1;
        waited  = 0;
      end
    end else if (holder < 0) begin
      nop_left--;
    end else if (granted) begin
      if (!req[holder]) granted = 0;
      else if (req[1-holder]) begin
        if (waited < MH) waited++;
      end else if (waited < MH) waited = 0;
    end else if (idle[holder]) begin
      holder   = -1;
      nop_left = GC;
    end
    e_pins = (holder < 0) ? NOP : mpins(holder);
    p_sync = p_mid;
    p_mid  = pref;
  endtask

  task automatic compare();
    logic [1:0] eg, eo, ey;
    eo = (holder < 0) ? 2'b00 : ((holder == 0) ? 2'b01 : 2'b10);
    eg = granted ? eo : 2'b00;
    ey = (granted && waited == MH) ? eo : 2'b00;
    check("gnt", gnt, eg);
    check("owner", own, eo);
    check("yield", yld, ey);
    check("pins", {dcmd, daddr, dba, ddqm, dcke}, e_pins);
    check("gnt_onehot0", ($countones(gnt) <= 1), 1);
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_edge();
    else       model_reset();
    @(negedge clk);
    compare();
  endtask

  task automatic rnd_pins();
    c0 = 4'($urandom);  a0 = 13'($urandom); b0 = 2'($urandom); d0 = 2'($urandom); k0 = 1'($urandom);
    c1 = 4'($urandom);  a1 = 13'($urandom); b1 = 2'($urandom); d1 = 2'($urandom); k1 = 1'($urandom);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; pref = 1'b0; req = 2'b00; idle = 2'b00;
    rnd_pins();
    model_reset();

    // reset with random requests
    repeat (5) begin
      req = 2'($urandom);
      rnd_pins();
      cyc();
    end
    check("rst_cmd", dcmd, 4'b1111);
    check("rst_dqm", ddqm, 2'b11);
    rst_n = 1'b1;
    req   = 2'b00;
    repeat (4) cyc();

    // single request and pin latency
    req = 2'b01;
    cyc();
    check("single_gnt", gnt, 2'b01);
    check("single_owner", own, 2'b01);
    c0 = 4'b0011;
    cyc();
    check("pin_latency", dcmd, 4'b0011);

    // handover cam -> hps
    req = 2'b11;
    repeat (3) cyc();
    req = 2'b10;
    k = 0;
    for (int i = 1; i <= 30; i++) begin
      cyc();
      if (i == 1) check("drain_gnt", gnt, 2'b00);
      if (i == 3) idle = 2'b01;
      if (i >= 4 && i <= 7) check("guard_nop", dcmd, 4'b1111);
      if (gnt == 2'b10) begin k = i; break; end
    end
    check("handover_gap", k, 9);

    // tie break by synchronised preference
    req = 2'b00; idle = 2'b11;
    repeat (12) cyc();
    pref = 1'b1;
    repeat (3) cyc();
    req = 2'b11;
    cyc();
    check("tie_cam", gnt, 2'b01);
    req = 2'b00;
    repeat (12) cyc();
    pref = 1'b0;
    repeat (3) cyc();
    req = 2'b11;
    cyc();
    check("tie_hps", gnt, 2'b10);

    // hog timeout
    req = 2'b00;
    repeat (12) cyc();
    req = 2'b01;
    cyc();
    req = 2'b11;
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (yld == 2'b01) begin k = i; break; end
    end
    check("hog_wait", k, 16);
    req = 2'b10;
    cyc();
    check("yield_drain", yld, 2'b00);

    // async reset while an ACTIVE command is on the pins
    req = 2'b01;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (gnt == 2'b01) break;
    end
    check("rst_setup", gnt, 2'b01);
    c0 = 4'b0011;
    cyc();
    check("active_on_pins", dcmd, 4'b0011);
    #3 rst_n = 1'b0;
    #1 check("rst_async_cmd", dcmd, 4'b1111);
    check("rst_async_owner", own, 2'b00);
    model_reset();
    repeat (2) cyc();
    rst_n = 1'b1;
    req   = 2'b00;
    cyc();
    req = 2'b10;
    cyc();
    check("post_rst_gnt", gnt, 2'b10);

    // random soak
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0)  req[0] = ~req[0];
      if ($urandom_range(7) == 0)  req[1] = ~req[1];
      if ($urandom_range(31) == 0) pref = ~pref;
      idle = 2'($urandom);
      rnd_pins();
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
